// File: rtl/wb_pkg.sv
// Shared types for the writeback load-merge unit: access sizes, FSM states
// and the per-access metadata carried across a split load.
package wb_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE   = 2'd0,
      SZ_HALF   = 2'd1,
      SZ_WORD   = 2'd2,
      SZ_DOUBLE = 2'd3
   } size_e;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_WAIT_HI = 1'b1
   } state_e;

   // Offset is sized for the widest supported beat (64 bits -> 3 bits).
   localparam int META_OFF_W = 3;

   typedef struct packed {
      size_e                 size;
      logic                  is_signed;
      logic [META_OFF_W-1:0] offset;
   } meta_t;

endpackage

// File: rtl/wb_load_merge_if.sv
// Load beat in / formatted result out bundle between memory return and writeback.
interface wb_load_merge_if #(
   parameter int DATA_W = 32
) ();
   localparam int OFF_W = $clog2(DATA_W/8);

   logic              in_valid;
   logic [1:0]        in_size;
   logic              in_signed;
   logic [OFF_W-1:0]  in_offset;
   logic [DATA_W-1:0] in_data;
   logic              busy;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_err;

   modport master (
      output in_valid, in_size, in_signed, in_offset, in_data,
      input  busy, out_valid, out_data, out_err
   );

   modport slave (
      input  in_valid, in_size, in_signed, in_offset, in_data,
      output busy, out_valid, out_data, out_err
   );
endinterface

// File: rtl/load_extract.sv
// Combinational extract: shift a two-beat window down by the byte offset,
// keep the access bytes and sign- or zero-extend to the register width.
module load_extract
   import wb_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [2*DATA_W-1:0] i_vec,
   input  meta_t               i_meta,
   output logic [DATA_W-1:0]   o_res
);
   logic [2*DATA_W-1:0] w_shift;
   logic                w_sign;
   int                  w_nbits;

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      w_shift = i_vec >> {i_meta.offset, 3'b000};
      w_nbits = 8 << i_meta.size;
      o_res   = w_shift[DATA_W-1:0];
      unique case (i_meta.size)
         SZ_BYTE: w_sign = i_meta.is_signed & w_shift[7];
         SZ_HALF: w_sign = i_meta.is_signed & w_shift[15];
         default: w_sign = i_meta.is_signed & w_shift[31];
      endcase
      // Full-width accesses pass through untouched.
      if (w_nbits < DATA_W) begin
         for (int i = 0; i < DATA_W; i++) begin
            if (i >= w_nbits) o_res[i] = w_sign;
         end
      end
   end
endmodule

// File: rtl/wb_load_merge.sv
// Writeback load formatter: aligned loads finish in one beat, loads that
// cross the beat boundary buffer the low beat and merge it with the next.
module wb_load_merge
   import wb_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter bit SIGN_EXT_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clk_en,
   input  logic              halt,
   input  logic              flush,
   wb_load_merge_if.slave    bus
);
   localparam int OFF_W = $clog2(DATA_W/8);
   localparam logic [4:0] NB = 5'(DATA_W/8);

   state_e              r_state;
   logic [DATA_W-1:0]   r_lo_buf;
   meta_t               r_meta_buf;
   logic                r_out_valid;
   logic                r_out_err;
   logic [DATA_W-1:0]   r_out_data;

   state_e              w_next;
   logic                w_nxt_valid;
   logic                w_nxt_err;
   logic [DATA_W-1:0]   w_nxt_data;
   logic                w_capture;
   logic [4:0]          w_bytes;
   logic [4:0]          w_end;
   logic                w_illegal;
   logic                w_split;
   meta_t               w_meta_in;
   meta_t               w_meta_sel;
   logic [2*DATA_W-1:0] w_vec;
   logic [DATA_W-1:0]   w_ext;

   assign w_bytes   = 5'd1 << bus.in_size;
   assign w_end     = 5'(bus.in_offset) + w_bytes;
   assign w_illegal = w_bytes > NB;
   assign w_split   = w_end > NB;

   assign w_meta_in.size      = size_e'(bus.in_size);
   assign w_meta_in.is_signed = bus.in_signed & SIGN_EXT_EN;
   assign w_meta_in.offset    = META_OFF_W'(bus.in_offset);

   // In WAIT_HI the incoming beat is always the high half of the buffered access.
   assign w_vec      = (r_state == ST_WAIT_HI) ? {bus.in_data, r_lo_buf}
                                               : {{DATA_W{1'b0}}, bus.in_data};
   assign w_meta_sel = (r_state == ST_WAIT_HI) ? r_meta_buf : w_meta_in;

   load_extract #(.DATA_W(DATA_W)) u_extract (
      .i_vec  (w_vec),
      .i_meta (w_meta_sel),
      .o_res  (w_ext)
   );

   always_comb begin
      w_next      = r_state;
      w_nxt_valid = 1'b0;
      w_nxt_err   = 1'b0;
      w_nxt_data  = r_out_data;
      w_capture   = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (bus.in_valid) begin
               if (w_illegal) begin
                  w_nxt_valid = 1'b1;
                  w_nxt_err   = 1'b1;
                  w_nxt_data  = '0;
               end else if (!w_split) begin
                  w_nxt_valid = 1'b1;
                  w_nxt_data  = w_ext;
               end else begin
                  w_capture = 1'b1;
                  w_next    = ST_WAIT_HI;
               end
            end
         end
         ST_WAIT_HI: begin
            if (bus.in_valid) begin
               w_nxt_valid = 1'b1;
               w_nxt_data  = w_ext;
               w_next      = ST_IDLE;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_lo_buf    <= '0;
         r_meta_buf  <= '0;
         r_out_valid <= 1'b0;
         r_out_err   <= 1'b0;
         r_out_data  <= '0;
      end else if (flush) begin
         r_state     <= ST_IDLE;
         r_out_valid <= 1'b0;
         r_out_err   <= 1'b0;
      end else if (clk_en && !halt) begin
         r_state     <= w_next;
         r_out_valid <= w_nxt_valid;
         r_out_err   <= w_nxt_err;
         r_out_data  <= w_nxt_data;
         if (w_capture) begin
            r_lo_buf   <= bus.in_data;
            r_meta_buf <= w_meta_in;
         end
      end
   end

   assign bus.busy      = (r_state == ST_WAIT_HI);
   assign bus.out_valid = r_out_valid;
   assign bus.out_err   = r_out_err;
   assign bus.out_data  = r_out_data;
endmodule
